// File: rtl/multi_cycle_control.sv
// Multi-cycle datapath controller: fetch/decode/execute sequencer that
// drives the datapath mux selects and memory/register write strobes.
module multi_cycle_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] opcode,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_write_cond_eq,
  output logic       pc_write_cond_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dest,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal
);

  localparam int unsigned OP_W = 6;

  localparam logic [OP_W-1:0] OP_R    = 6'b101101;
  localparam logic [OP_W-1:0] OP_LW   = 6'b101110;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101111;
  localparam logic [OP_W-1:0] OP_J    = 6'b110000;
  localparam logic [OP_W-1:0] OP_BEQ  = 6'b110001;
  localparam logic [OP_W-1:0] OP_BNE  = 6'b110010;
  localparam logic [OP_W-1:0] OP_ADDI = 6'b110011;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_t;

  state_t          state_q;
  state_t          state_d;
  logic [OP_W-1:0] op;
  logic            unused_opcode_hi;

  // Only the low six opcode bits carry meaning
  assign op               = opcode[OP_W-1:0];
  assign unused_opcode_hi = ^opcode[7:6];
  assign state            = 4'(state_q);

  // State register; reset returns to FETCH immediately, abandoning any instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Next-state and control decode from the current state (and mem_ready in wait states)
  always_comb begin
    state_d          = state_q;
    pc_write         = 1'b0;
    pc_write_cond_eq = 1'b0;
    pc_write_cond_ne = 1'b0;
    iord             = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    mem_to_reg       = 1'b0;
    reg_dest         = 1'b0;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = 2'b00;
    alu_op           = 2'b00;
    pc_source        = 2'b00;
    instr_done       = 1'b0;
    illegal          = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target computed speculatively while the opcode is decoded
        alu_src_b = 2'b11;
        case (op)
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_R:            state_d = S_R_EXEC;
          OP_BEQ, OP_BNE:  state_d = S_BRANCH;
          OP_J:            state_d = S_JUMP;
          OP_ADDI:         state_d = S_ADDI_EXEC;
          default:         state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        if (op == OP_LW)      state_d = S_MEM_RD;
        else if (op == OP_SW) state_d = S_MEM_WR;
        else                  state_d = S_TRAP;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_dest   = 1'b1;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a        = 1'b1;
        alu_op           = 2'b01;
        pc_source        = 2'b01;
        pc_write_cond_eq = (op == OP_BEQ);
        pc_write_cond_ne = (op == OP_BNE);
        instr_done       = 1'b1;
        state_d          = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'b10;
        pc_write   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
        illegal = 1'b1;
        state_d = S_TRAP;
      end
      default: state_d = S_TRAP;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed bench for multi_cycle_control: per-cycle state and control vector checks.
module tb_multi_cycle_control;

  logic       clk;
  logic       rst_n;
  logic [7:0] opcode;
  logic       mem_ready;
  logic       pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       instr_done, illegal;

  int checks   = 0;
  int failures = 0;

  multi_cycle_control dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond_eq(pc_write_cond_eq),
    .pc_write_cond_ne(pc_write_cond_ne), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
    .reg_dest(reg_dest), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
    .state(state), .instr_done(instr_done), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Flattened control vector:
  // pcw eq ne iord mr mw irw m2r rd rw asa | asb(2) aop(2) pcs(2) | done ill
  logic [18:0] ctrl;
  assign ctrl = {pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read,
                 mem_write, ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a,
                 alu_src_b, alu_op, pc_source, instr_done, illegal};

  //                                  pew ne io mr mw ir m2 rd rw aa  asb    aop    pcs   dn  il
  localparam logic [18:0] F_W  = {7'b0000100, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] F_R  = {7'b1000101, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] DEC  = {7'b0000000, 4'b0000, 2'b11, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] MADR = {7'b0000000, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] MRD  = {7'b0001100, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] MWB  = {7'b0000000, 4'b1010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] MWR  = {7'b0001010, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] MWRD = {7'b0001010, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] REX  = {7'b0000000, 4'b0001, 2'b00, 2'b10, 2'b00, 2'b00};
  localparam logic [18:0] RWB  = {7'b0000000, 4'b0110, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] BEQ  = {7'b0100000, 4'b0001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [18:0] BNE  = {7'b0010000, 4'b0001, 2'b00, 2'b01, 2'b01, 2'b10};
  localparam logic [18:0] JMP  = {7'b1000000, 4'b0000, 2'b00, 2'b00, 2'b10, 2'b10};
  localparam logic [18:0] AEX  = {7'b0000000, 4'b0001, 2'b10, 2'b00, 2'b00, 2'b00};
  localparam logic [18:0] AWB  = {7'b0000000, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b10};
  localparam logic [18:0] TRP  = {7'b0000000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b01};

  typedef struct {
    logic        mr;
    logic [3:0]  st;
    logic [18:0] c;
  } vec_t;

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b0; opcode = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 4'd0 || ctrl !== F_W) begin
      failures++;
      $display("FAIL reset state=%0d ctrl=%h expected state=0 ctrl=%h", state, ctrl, F_W);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_lw();
    vec_t v[5] = '{'{1'b1, 4'd0, F_R}, '{1'b1, 4'd1, DEC}, '{1'b1, 4'd2, MADR},
                   '{1'b1, 4'd3, MRD}, '{1'b1, 4'd4, MWB}};
    opcode = 8'h2E;
    foreach (v[i]) begin
      @(negedge clk); mem_ready = v[i].mr; #1;
      checks++;
      if (state !== v[i].st || ctrl !== v[i].c) begin
        failures++;
        $display("FAIL lw[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, v[i].st, v[i].c);
      end
    end
  endtask

  task automatic test_sw_wait();
    vec_t v[7] = '{'{1'b1, 4'd0, F_R}, '{1'b1, 4'd1, DEC}, '{1'b1, 4'd2, MADR},
                   '{1'b0, 4'd5, MWR}, '{1'b0, 4'd5, MWR}, '{1'b0, 4'd5, MWR},
                   '{1'b1, 4'd5, MWRD}};
    opcode = 8'h2F;
    foreach (v[i]) begin
      @(negedge clk); mem_ready = v[i].mr; #1;
      checks++;
      if (state !== v[i].st || ctrl !== v[i].c) begin
        failures++;
        $display("FAIL sw_wait[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, v[i].st, v[i].c);
      end
    end
  endtask

  task automatic test_r_fetch_wait();
    vec_t v[6] = '{'{1'b0, 4'd0, F_W}, '{1'b0, 4'd0, F_W}, '{1'b1, 4'd0, F_R},
                   '{1'b0, 4'd1, DEC}, '{1'b0, 4'd6, REX}, '{1'b0, 4'd7, RWB}};
    opcode = 8'h2D;
    foreach (v[i]) begin
      @(negedge clk); mem_ready = v[i].mr; #1;
      checks++;
      if (state !== v[i].st || ctrl !== v[i].c) begin
        failures++;
        $display("FAIL r_exec[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, v[i].st, v[i].c);
      end
    end
  endtask

  task automatic test_branch();
    vec_t v[6] = '{'{1'b1, 4'd0, F_R}, '{1'b1, 4'd1, DEC}, '{1'b1, 4'd8, BEQ},
                   '{1'b1, 4'd0, F_R}, '{1'b1, 4'd1, DEC}, '{1'b1, 4'd8, BNE}};
    foreach (v[i]) begin
      @(negedge clk);
      if (i == 0) opcode = 8'h31;
      if (i == 3) opcode = 8'h32;
      mem_ready = v[i].mr; #1;
      checks++;
      if (state !== v[i].st || ctrl !== v[i].c) begin
        failures++;
        $display("FAIL branch[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, v[i].st, v[i].c);
      end
    end
  endtask

  task automatic test_jump_addi();
    vec_t v[8] = '{'{1'b1, 4'd0, F_R}, '{1'b1, 4'd1, DEC}, '{1'b1, 4'd9, JMP},
                   '{1'b1, 4'd0, F_R}, '{1'b1, 4'd1, DEC}, '{1'b1, 4'd10, AEX},
                   '{1'b1, 4'd11, AWB}, '{1'b0, 4'd0, F_W}};
    foreach (v[i]) begin
      @(negedge clk);
      if (i == 0) opcode = 8'h30;
      if (i == 3) opcode = 8'hF3;
      mem_ready = v[i].mr; #1;
      checks++;
      if (state !== v[i].st || ctrl !== v[i].c) begin
        failures++;
        $display("FAIL jump_addi[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, v[i].st, v[i].c);
      end
    end
  endtask

  task automatic test_trap();
    vec_t v[2] = '{'{1'b1, 4'd0, F_R}, '{1'b1, 4'd1, DEC}};
    opcode = 8'h00;
    foreach (v[i]) begin
      @(negedge clk); mem_ready = v[i].mr; #1;
      checks++;
      if (state !== v[i].st || ctrl !== v[i].c) begin
        failures++;
        $display("FAIL trap_entry[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, v[i].st, v[i].c);
      end
    end
    // Trap must hold regardless of mem_ready or opcode activity
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); mem_ready = k[0]; opcode = (k[1]) ? 8'h2E : 8'h00; #1;
      checks++;
      if (state !== 4'd12 || ctrl !== TRP) begin
        failures++;
        $display("FAIL trap_hold[%0d] state=%0d ctrl=%h expected state=12 ctrl=%h", k, state, ctrl, TRP);
      end
    end
    // Reset drop mid-cycle: effect must be visible before any clock edge
    @(negedge clk); mem_ready = 1'b0; #1;
    rst_n = 1'b0; #1;
    checks++;
    if (state !== 4'd0 || illegal !== 1'b0 || ctrl !== F_W) begin
      failures++;
      $display("FAIL trap_async_reset state=%0d illegal=%b ctrl=%h expected state=0 illegal=0 ctrl=%h", state, illegal, ctrl, F_W);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_async_reset_mem_rd();
    vec_t v[5] = '{'{1'b1, 4'd0, F_R}, '{1'b1, 4'd1, DEC}, '{1'b1, 4'd2, MADR},
                   '{1'b0, 4'd3, MRD}, '{1'b0, 4'd3, MRD}};
    opcode = 8'h2E;
    foreach (v[i]) begin
      @(negedge clk); mem_ready = v[i].mr; #1;
      checks++;
      if (state !== v[i].st || ctrl !== v[i].c) begin
        failures++;
        $display("FAIL mem_rd_wait[%0d] state=%0d ctrl=%h expected state=%0d ctrl=%h", i, state, ctrl, v[i].st, v[i].c);
      end
    end
    #1 rst_n = 1'b0; #1;
    checks++;
    if (state !== 4'd0 || ctrl !== F_W) begin
      failures++;
      $display("FAIL mem_rd_async_reset state=%0d ctrl=%h expected state=0 ctrl=%h", state, ctrl, F_W);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // First cycles after release: still fetching, no register or memory write
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      checks++;
      if (state !== 4'd0 || ctrl !== F_W) begin
        failures++;
        $display("FAIL post_reset[%0d] state=%0d ctrl=%h expected state=0 ctrl=%h", k, state, ctrl, F_W);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout state=%0d", state);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_r_fetch_wait();
    test_branch();
    test_jump_addi();
    test_async_reset_mem_rd();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_cycle_control.md
MULTI_CYCLE_CONTROL -- requirements
Module: multi_cycle_control

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: opcode  input  8  IR opcode field; only bits [5:0] decoded, [7:6] ignored; valid from DECODE onward.
REQ-004 SHALL have port: mem_ready  input  1  memory completes current read/write this cycle.
REQ-005 SHALL have outputs (all 1-bit): pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dest, reg_write, alu_src_a.
REQ-006 SHALL have 2-bit outputs: alu_src_b (00 reg B, 01 const 4, 10 sign-ext imm, 11 imm<<2), alu_op (00 add, 01 sub, 10 funct), pc_source (00 ALU, 01 ALUOut, 10 jump target).
REQ-007 SHALL have outputs: state  output  4  current state code; instr_done  output  1  last-cycle pulse; illegal  output  1  sticky trap flag.

Function
REQ-008 SHALL decode opcode[5:0]: 101101 R, 101110 LW, 101111 SW, 110000 J, 110001 BEQ, 110010 BNE, 110011 ADDI; all other values illegal.
REQ-009 SHALL use state codes: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, R_EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11, TRAP 12; codes 13-15 SHALL go to TRAP next cycle.
REQ-010 SHALL drive every output not listed for a state to 0.
REQ-011 FETCH: mem_read=1, alu_src_b=01; ir_write=1 and pc_write=1 only in the cycle mem_ready=1; stay while mem_ready=0, else go DECODE.
REQ-012 DECODE: alu_src_b=11 (branch target precompute); next: LW/SW->MEM_ADDR, R->R_EXEC, BEQ/BNE->BRANCH, J->JUMP, ADDI->ADDI_EXEC, illegal->TRAP.
REQ-013 MEM_ADDR: alu_src_a=1, alu_src_b=10; next MEM_RD if LW, MEM_WR if SW.
REQ-014 MEM_RD: iord=1, mem_read=1; stay while mem_ready=0, else MEM_WB.
REQ-015 MEM_WB: mem_to_reg=1, reg_write=1, reg_dest=0; next FETCH.
REQ-016 MEM_WR: iord=1, mem_write=1; stay while mem_ready=0, else FETCH.
REQ-017 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10; next R_WB. R_WB: reg_dest=1, reg_write=1; next FETCH.
REQ-018 BRANCH: alu_src_a=1, alu_op=01, pc_source=01, pc_write_cond_eq=1 for BEQ, pc_write_cond_ne=1 for BNE (never both); next FETCH.
REQ-019 JUMP: pc_source=10, pc_write=1; next FETCH.
REQ-020 ADDI_EXEC: alu_src_a=1, alu_src_b=10, alu_op=00; next ADDI_WB. ADDI_WB: reg_write=1, reg_dest=0, mem_to_reg=0; next FETCH.
REQ-021 TRAP: all control outputs 0, illegal=1; remain until reset.
REQ-022 instr_done SHALL be 1 in MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, and in MEM_WR when mem_ready=1; else 0.
REQ-023 Latency with mem_ready always 1: LW 5, SW 4, R 4, ADDI 4, BEQ/BNE 3, J 3 cycles; each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds one.
REQ-024 mem_ready SHALL be ignored in all states other than FETCH, MEM_RD, MEM_WR.
REQ-025 mem_read and mem_write SHALL never be 1 in the same cycle; reg_write and pc_write likewise.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force state=FETCH and illegal=0; outputs then follow FETCH decode with ir_write=pc_write=0 until mem_ready=1.
REQ-027 Reset asserted mid-instruction (any state, incl. wait states or TRAP) SHALL abandon it; no write strobe SHALL assert during or on the first cycle after release unless FETCH sees mem_ready=1.

Verification
REQ-028 opcode=0x2E, mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 and mem_to_reg=1 only in cycle 5; instr_done pulse in state 4.
REQ-029 opcode=0x2F, mem_ready low 3 cycles in MEM_WR -> state 5 held 4 cycles, mem_write=1 throughout, instr_done only on the mem_ready=1 cycle.
REQ-030 opcode=0x31 then 0x32 -> BRANCH with pc_write_cond_eq=1/ne=0, then eq=0/ne=1; alu_op=01, pc_source=01 both times.
REQ-031 opcode=0x30 -> 0,1,9,0; pc_write=1, pc_source=10 in JUMP; opcode=0xF3 behaves as ADDI (0,1,10,11,0).
REQ-032 opcode=0x00 -> TRAP (12), illegal=1 held for 20 cycles with all strobes 0; rst_n pulse low -> state=0, illegal=0 immediately.
REQ-033 rst_n low asynchronously during MEM_RD wait -> state=0 without waiting for clk edge; no reg_write afterward.
